tri_bus_arbiter: RTL
====================

Name: tri_bus_arbiter

Overview:
- N-channel arbiter that owns a shared W-bit tristate bus; generalises the single enable-driven tristate buffer to N drivers.
- Guarantees at most one driver enabled per cycle, with round-robin fairness and a hold-time cap.
- Inserts one all-Z turnaround cycle on every ownership change.
- Sits between CPU-side requesters (register file, ALU, memory port) and the internal data bus.

Parameters:
- N, 4, number of requesting channels (2..16)
- W, 8, bus data width
- MAX_HOLD, 8, maximum consecutive GRANT cycles per owner before forced rotation (1..255)
- OWN_W, $clog2(N), width of owner index

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  N  per-channel bus request, level-sensitive
- din  input  N*W  per-channel data, channel i at din[i*W +: W]
- gnt  output  N  one-hot grant, registered
- bus  output (tri)  W  shared bus, driven only by the granted channel, else Z
- bus_valid  output  1  high when bus carries granted data
- owner  output  OWN_W  index of current owner, valid when bus_valid=1

Behaviour:
- Reset: state=IDLE, gnt=0, bus=Z (all bits), bus_valid=0, owner=0, rr_ptr=0, hold_cnt=0.
- States IDLE, GRANT, TURN. State and gnt are registered; bus enables derive only from registered gnt, so gnt is never more than one-hot.
- IDLE: if any req is set, pick the first requester at or after rr_ptr (circular search). Next cycle: GRANT, gnt one-hot, hold_cnt=1. Latency from req to bus drive is 1 cycle.
- GRANT: bus = din of owner (combinational from din, enable registered); bus_valid=1.
  - Owner drops req: next state TURN.
  - hold_cnt==MAX_HOLD and another req is pending: next state TURN (forced rotation).
  - hold_cnt==MAX_HOLD and no other req: stay in GRANT; hold_cnt saturates at MAX_HOLD.
  - Otherwise stay in GRANT; hold_cnt increments.
- Leaving GRANT: rr_ptr = owner+1, wrapping N-1 to 0.
- TURN: lasts exactly 1 cycle. gnt=0, bus=Z, bus_valid=0. Next state IDLE-arbitration evaluated in the same cycle: if any req is set, go directly to GRANT of the new winner, otherwise IDLE. A changed owner therefore gets the bus 2 cycles after the old owner is released.
- Same-owner re-grant after TURN is allowed if it is the only requester.
- req changes mid-GRANT by non-owners have no effect until rotation.
- rst asserted in any state: next cycle all outputs return to reset values; the bus is released immediately at that edge.
- owner holds its last value in IDLE/TURN (bus_valid qualifies it).

Optional Feature:
- Macro: TRI_BUS_KEEPER_EN
- Defined: in IDLE/TURN the bus is driven by an internal keeper holding the last granted value (reset value 0), not Z. bus_valid behaviour is unchanged. The keeper enable is the NOR of gnt, so there is still only one driver per cycle.
- Undefined: bus is Z whenever gnt==0.

Decomposition:
- Package tri_bus_pkg: state enum (IDLE=2'd0, GRANT=2'd1, TURN=2'd2) and default constants for N, W, MAX_HOLD.
- Sub-module tri_driver (W, in, enable, out) with out = enable ? in : Z. Instantiate it N times, plus once for the keeper when TRI_BUS_KEEPER_EN is defined.
- Arbitration function (rotate, priority-encode) stays local.

Test Plan:
- Reset: hold rst 3 cycles with req=4'b1111 -> gnt=0, bus=8'hZZ, bus_valid=0 throughout. First grant goes to ch0, 1 cycle after rst falls.
- Single requester: req=4'b0100, din[2]=8'h5A -> cycle+1 gnt=4'b0100, bus=8'h5A, owner=2. Drop req -> TURN cycle with bus=Z, then IDLE.
- Round-robin: req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0. Each holds 8 cycles, separated by 1 Z cycle. gnt is never multi-hot, checked every cycle.
- Hold saturation: only ch1 requests for 20 cycles -> gnt stays 4'b0010 and bus_valid=1 for the full 20 cycles, with no TURN.
- Handover contention, mirroring the two-driver case: ch0 din=8'h02, ch1 din=8'h03. ch0 releases while ch1 requests -> bus sequence 02, Z, 03. No X is resolved on the bus in any cycle.
- Mid-grant reset: with ch3 owning the bus, pulse rst for 1 cycle -> next cycle bus=Z and gnt=0. After reset, arbitration restarts from rr_ptr=0. With TRI_BUS_KEEPER_EN defined, the bus instead reads 8'h00 after reset and the last value in TURN.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and default sizing for the tristate bus arbiter.
// Optional keeper build: define TRI_BUS_KEEPER_EN.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_W        = 8;
   localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/tri_bus_arbiter_tri_driver.sv
// Single enable-driven tristate buffer; one instance per bus driver.
module tri_driver #(
   parameter int W = 8
) (
   input  logic [W-1:0] in,
   input  logic         enable,
   output tri   [W-1:0] out
);

   assign out = enable ? in : {W{1'bz}};

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with hold cap and one Z turnaround cycle.
// Define TRI_BUS_KEEPER_EN to hold the last granted value on the bus while idle.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int W        = DEF_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int OWN_W    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*W-1:0]     din,
   output logic [N-1:0]       gnt,
   output tri   [W-1:0]       bus,
   output logic               bus_valid,
   output logic [OWN_W-1:0]   owner
);

   state_t             state_reg, state_next;
   logic [N-1:0]       gnt_reg, gnt_next;
   logic [OWN_W-1:0]   owner_reg, owner_next;
   logic [OWN_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [7:0]         hold_cnt_reg, hold_cnt_next;
   logic [OWN_W-1:0]   winner;
   logic [OWN_W-1:0]   owner_inc;
   logic               hold_full;
   logic               others_pending;

   // Circular priority search starting at ptr.
   function automatic logic [OWN_W-1:0] pick_winner(input logic [N-1:0] r,
                                                    input logic [OWN_W-1:0] ptr);
      logic [OWN_W-1:0] w;
      logic             found;
      int               idx;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && r[idx]) begin
            w     = OWN_W'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign winner         = pick_winner(req, rr_ptr_reg);
   assign owner_inc      = (owner_reg == OWN_W'(N - 1)) ? '0 : owner_reg + 1'b1;
   assign hold_full      = (hold_cnt_reg == 8'(MAX_HOLD));
   assign others_pending = |(req & ~gnt_reg);

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      owner_next    = owner_reg;
      rr_ptr_next   = rr_ptr_reg;
      hold_cnt_next = hold_cnt_reg;
      case (state_reg)
         IDLE, TURN: begin
            gnt_next   = '0;
            state_next = IDLE;
            if (|req) begin
               state_next    = GRANT;
               gnt_next      = N'(1) << winner;
               owner_next    = winner;
               hold_cnt_next = 8'd1;
            end
         end
         GRANT: begin
            if (!req[owner_reg] || (hold_full && others_pending)) begin
               state_next  = TURN;
               gnt_next    = '0;
               rr_ptr_next = owner_inc;
            end else if (!hold_full) begin
               hold_cnt_next = hold_cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         gnt_reg      <= '0;
         owner_reg    <= '0;
         rr_ptr_reg   <= '0;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         owner_reg    <= owner_next;
         rr_ptr_reg   <= rr_ptr_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   assign gnt       = gnt_reg;
   assign bus_valid = |gnt_reg;
   assign owner     = owner_reg;

   // Enables come straight from the registered one-hot grant.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_drv
         tri_driver #(.W(W)) u_drv (
            .in     (din[gi*W +: W]),
            .enable (gnt_reg[gi]),
            .out    (bus)
         );
      end
   endgenerate

`ifdef TRI_BUS_KEEPER_EN
   logic [W-1:0] keeper_reg;
   logic [W-1:0] owner_data;

   assign owner_data = din[owner_reg*W +: W];

   always_ff @(posedge clk) begin
      if (rst) begin
         keeper_reg <= '0;
      end else if (|gnt_reg) begin
         keeper_reg <= owner_data;
      end
   end

   // Keeper drives only when no channel is granted.
   tri_driver #(.W(W)) u_keeper (
      .in     (keeper_reg),
      .enable (~|gnt_reg),
      .out    (bus)
   );
`else
`endif

endmodule
